// File: rtl/axi4l_regbank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and the
// write/read engine state encodings.
package axi4l_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_ADDR,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_ADDR,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4l_regbank_if.sv
// AXI4-Lite bus bundle between an interconnect port (master) and the
// register bank (slave).
interface axi4l_regbank_if #(
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [ADDR_SIZE-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   rvalid;
    logic                   rready;
    logic [DATA_SIZE-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4l_regbank_wr.sv
// Write engine of the register bank: accepts AW and W in any order, holds
// whichever arrives first, and on the edge both are present issues a
// one-cycle commit (byte-merged word) to the register array, then holds
// the B response until it is taken.
// Optional: AXI4L_REGBANK_PROT_EN rejects unprivileged writes (awprot[0]==0).
module axi4l_regbank_wr import axi4l_regbank_pkg::*; #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int NREGS     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_SIZE-1:0]       awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_SIZE-1:0]       wdata,
    input  logic [DATA_SIZE/8-1:0]     wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic [NREGS*DATA_SIZE-1:0] regs_i,
    output logic                       wr_en_o,
    output logic [ADDR_SIZE-3:0]       wr_idx_o,
    output logic [DATA_SIZE-1:0]       wr_data_o
);
    localparam int IDXW = ADDR_SIZE - 2;
    localparam int NB   = DATA_SIZE / 8;

    wr_state_t          state_q,  state_d;
    logic               aw_cap_q, aw_cap_d;
    logic               w_cap_q,  w_cap_d;
    logic [IDXW-1:0]    awidx_q,  awidx_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [NB-1:0]      wstrb_q,  wstrb_d;
    resp_t              bresp_q,  bresp_d;

    logic               aw_fire, w_fire, aw_have, w_have;
    logic [IDXW-1:0]    idx_eff;
    logic [DATA_SIZE-1:0] data_eff, old_word;
    logic [NB-1:0]      strb_eff;
    logic               prot_ok, commit_err;
    logic               unused_awaddr;

    assign awready = (state_q == W_ADDR) && !aw_cap_q;
    assign wready  = (state_q == W_ADDR) && !w_cap_q;
    assign bvalid  = (state_q == W_RESP);
    assign bresp   = bresp_q;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign aw_have = aw_cap_q || aw_fire;
    assign w_have  = w_cap_q || w_fire;

    // Held copy wins over the live bus once a channel has been captured.
    assign idx_eff  = aw_cap_q ? awidx_q : awaddr[ADDR_SIZE-1:2];
    assign data_eff = w_cap_q  ? wdata_q : wdata;
    assign strb_eff = w_cap_q  ? wstrb_q : wstrb;
    assign unused_awaddr = ^awaddr[1:0];

`ifdef AXI4L_REGBANK_PROT_EN
    logic awpriv_q, awpriv_d;
    logic unused_awprot;
    assign unused_awprot = ^awprot[2:1];
    assign awpriv_d = aw_fire ? awprot[0] : awpriv_q;
    assign prot_ok  = aw_cap_q ? awpriv_q : awprot[0];

    // Privilege bit travels with the captured write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) awpriv_q <= 1'b0;
        else        awpriv_q <= awpriv_d;
    end
`else
    logic unused_awprot;
    assign unused_awprot = ^awprot;
    assign prot_ok = 1'b1;
`endif

    assign commit_err = (int'(idx_eff) >= NREGS) || !prot_ok;

    // Current contents of the target register, for the byte merge.
    always_comb begin
        old_word = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (int'(idx_eff) == k) old_word = regs_i[k*DATA_SIZE +: DATA_SIZE];
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign wr_data_o[gi*8 +: 8] = strb_eff[gi] ? data_eff[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
    assign wr_idx_o = idx_eff;

    // Next-state: capture channels, commit when both present, release on B handshake.
    always_comb begin
        state_d  = state_q;
        aw_cap_d = aw_cap_q;
        w_cap_d  = w_cap_q;
        awidx_d  = awidx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        wr_en_o  = 1'b0;
        unique case (state_q)
            W_ADDR: begin
                if (aw_fire) begin
                    aw_cap_d = 1'b1;
                    awidx_d  = awaddr[ADDR_SIZE-1:2];
                end
                if (w_fire) begin
                    w_cap_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if (aw_have && w_have) begin
                    state_d = W_RESP;
                    bresp_d = commit_err ? SLVERR : OKAY;
                    wr_en_o = !commit_err;
                end
            end
            W_RESP: begin
                if (bready) begin
                    state_d  = W_ADDR;
                    aw_cap_d = 1'b0;
                    w_cap_d  = 1'b0;
                end
            end
            default: state_d = W_ADDR;
        endcase
    end

    // State and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= W_ADDR;
            aw_cap_q <= 1'b0;
            w_cap_q  <= 1'b0;
            awidx_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
        end else begin
            state_q  <= state_d;
            aw_cap_q <= aw_cap_d;
            w_cap_q  <= w_cap_d;
            awidx_q  <= awidx_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
        end
    end
endmodule

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank: NREGS read/write registers exported flat
// on regs_o. Write path lives in axi4l_regbank_wr; read path and the
// register array live here. A read accepted on the same edge as a write
// commit returns the pre-write value.
// Optional: AXI4L_REGBANK_PROT_EN rejects unprivileged accesses (prot[0]==0).
module axi4l_regbank import axi4l_regbank_pkg::*; #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int NREGS     = 8,
    parameter logic [DATA_SIZE-1:0] RESET_VAL = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    axi4l_regbank_if.slave             bus,
    output logic [NREGS*DATA_SIZE-1:0] regs_o
);
    localparam int IDXW = ADDR_SIZE - 2;

    logic [DATA_SIZE-1:0] regs_q [NREGS];
    logic [DATA_SIZE-1:0] regs_d [NREGS];
    logic [NREGS*DATA_SIZE-1:0] regs_flat;

    logic                 wr_en;
    logic [IDXW-1:0]      wr_idx;
    logic [DATA_SIZE-1:0] wr_data;

    rd_state_t            rd_state_q, rd_state_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    resp_t                rresp_q, rresp_d;

    logic [IDXW-1:0]      rd_idx;
    logic [DATA_SIZE-1:0] rd_word;
    logic                 rd_err, rd_prot_ok;
    logic                 unused_araddr;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
        assign regs_flat[gi*DATA_SIZE +: DATA_SIZE] = regs_q[gi];
    end
    assign regs_o = regs_flat;

    axi4l_regbank_wr #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .NREGS     (NREGS)
    ) u_wr (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .awvalid   (bus.awvalid),
        .awready   (bus.awready),
        .awaddr    (bus.awaddr),
        .awprot    (bus.awprot),
        .wvalid    (bus.wvalid),
        .wready    (bus.wready),
        .wdata     (bus.wdata),
        .wstrb     (bus.wstrb),
        .bvalid    (bus.bvalid),
        .bready    (bus.bready),
        .bresp     (bus.bresp),
        .regs_i    (regs_flat),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data)
    );

    // Register array next-state: apply the single merged commit word.
    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            regs_d[k] = regs_q[k];
            if (wr_en && (int'(wr_idx) == k)) regs_d[k] = wr_data;
        end
    end

    // Register array storage.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= RESET_VAL;
        end else begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
        end
    end

    assign rd_idx        = bus.araddr[ADDR_SIZE-1:2];
    assign unused_araddr = ^bus.araddr[1:0];

`ifdef AXI4L_REGBANK_PROT_EN
    logic unused_arprot;
    assign unused_arprot = ^bus.arprot[2:1];
    assign rd_prot_ok    = bus.arprot[0];
`else
    logic unused_arprot;
    assign unused_arprot = ^bus.arprot;
    assign rd_prot_ok    = 1'b1;
`endif

    assign rd_err = (int'(rd_idx) >= NREGS) || !rd_prot_ok;

    // Select the addressed register (pre-commit value).
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (int'(rd_idx) == k) rd_word = regs_q[k];
        end
    end

    assign bus.arready = (rd_state_q == R_ADDR);
    assign bus.rvalid  = (rd_state_q == R_DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // Read engine next-state: latch data on AR accept, hold until R handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            R_ADDR: begin
                if (bus.arvalid) begin
                    rd_state_d = R_DATA;
                    rdata_d    = rd_err ? '0 : rd_word;
                    rresp_d    = rd_err ? SLVERR : OKAY;
                end
            end
            R_DATA: begin
                if (bus.rready) rd_state_d = R_ADDR;
            end
            default: rd_state_d = R_ADDR;
        endcase
    end

    // Read engine state and response registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_q <= R_ADDR;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi4l_regbank.sv
// Directed + randomized bench for axi4l_regbank against an array model of
// the register file. Build with AXI4L_REGBANK_PROT_EN to exercise the
// privilege checks.
module tb_axi4l_regbank;
    logic         clk;
    logic         rst_n;
    logic [255:0] regs_o;
    int           checks;
    int           errors;
    logic [31:0]  model_regs [8];

    axi4l_regbank_if #(.ADDR_SIZE(10), .DATA_SIZE(32)) bus ();

    axi4l_regbank dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus),
        .regs_o  (regs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_priv(input logic [2:0] prot);
`ifdef AXI4L_REGBANK_PROT_EN
        return prot[0];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int k = 0; k < 8; k++) f[k*32 +: 32] = model_regs[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) model_regs[k] = 32'h0;
    endtask

    task automatic model_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input logic [2:0] prot, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < 8 && model_priv(prot)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [9:0] addr, input logic [2:0] prot,
                              output logic [31:0] data, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < 8 && model_priv(prot)) begin
            data = model_regs[idx];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endtask

    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int aw_dly, input int w_dly, input int b_dly,
                             input string tag);
        bit aw_done, w_done, aw_f, w_f;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        bus.awaddr = addr; bus.awprot = prot; bus.wdata = data; bus.wstrb = strb; bus.bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 64) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            cyc++;
            if (w_done && !aw_done) chk({tag, ":wready_held_low"}, bus.wready, 1'b0);
            if (aw_done && !w_done) chk({tag, ":awready_held_low"}, bus.awready, 1'b0);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk({tag, ":aw_w_accepted"}, aw_done && w_done, 1'b1);
        chk({tag, ":commit_latency"}, cyc, ((aw_dly > w_dly) ? aw_dly : w_dly) + 1);
        model_write(addr, data, strb, prot, exp_resp);
        chk({tag, ":bvalid"}, bus.bvalid, 1'b1);
        chk({tag, ":bresp"}, bus.bresp, exp_resp);
        chk({tag, ":regs_o"}, regs_o, model_flat());
        for (int i = 0; i < b_dly; i++) begin @(posedge clk); #1; end
        if (b_dly > 0) begin
            chk({tag, ":bvalid_held"}, bus.bvalid, 1'b1);
            chk({tag, ":bresp_held"}, bus.bresp, exp_resp);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk({tag, ":bvalid_cleared"}, bus.bvalid, 1'b0);
        chk({tag, ":ready_restored"}, {bus.awready, bus.wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [9:0] addr, input logic [2:0] prot, input int ar_dly,
                            input int r_dly, input string tag);
        bit ar_done, ar_f;
        int cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        ar_done = 1'b0; cyc = 0;
        bus.araddr = addr; bus.arprot = prot; bus.rready = 1'b0;
        while (!ar_done && cyc < 64) begin
            bus.arvalid = (cyc >= ar_dly);
            @(negedge clk);
            ar_f = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            ar_done = ar_f;
            cyc++;
        end
        bus.arvalid = 1'b0;
        chk({tag, ":ar_accepted"}, ar_done, 1'b1);
        chk({tag, ":ar_latency"}, cyc, ar_dly + 1);
        model_read(addr, prot, exp_data, exp_resp);
        chk({tag, ":rvalid"}, bus.rvalid, 1'b1);
        chk({tag, ":arready_low"}, bus.arready, 1'b0);
        chk({tag, ":rdata"}, bus.rdata, exp_data);
        chk({tag, ":rresp"}, bus.rresp, exp_resp);
        for (int i = 0; i < r_dly; i++) begin @(posedge clk); #1; end
        if (r_dly > 0) chk({tag, ":rdata_held"}, {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, exp_resp, exp_data});
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        chk({tag, ":rvalid_cleared"}, bus.rvalid, 1'b0);
        chk({tag, ":arready_restored"}, bus.arready, 1'b1);
    endtask

    initial begin
        logic [31:0] old0;
        logic [9:0]  raddr;
        checks = 0; errors = 0;
        model_reset();
        rst_n = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b001;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b001; bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("reset:valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("reset:resp_rdata", {bus.bresp, bus.rresp, bus.rdata}, '0);
        chk("reset:regs", regs_o, model_flat());
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Same-cycle AW+W, then read back.
        axi_write(10'h004, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0, "wr_same_cycle");
        axi_read(10'h004, 3'b001, 0, 0, "rd_reg1");

        // W well ahead of AW, partial strobe, slow bready.
        axi_write(10'h008, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0, 0, "wr_reg2_fill");
        axi_write(10'h008, 32'h11223344, 4'b0101, 3'b001, 3, 0, 5, "wr_w_first");
        chk("reg2_merged", regs_o[2*32 +: 32], 32'hFF22FF44);
        axi_write(10'h00B, 32'h99999999, 4'h0, 3'b001, 0, 2, 1, "wr_zero_strb");

        // Out-of-range accesses.
        axi_write(10'h020, 32'hCAFEF00D, 4'hF, 3'b001, 1, 1, 0, "wr_oob");
        axi_read(10'h3FC, 3'b001, 0, 2, "rd_oob");

        // Read accepted on the same edge as a write commit sees the old value.
        old0 = model_regs[0];
        bus.awaddr = 10'h000; bus.awprot = 3'b001; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
        bus.araddr = 10'h000; bus.arprot = 3'b001;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("same_edge:valids", {bus.bvalid, bus.rvalid}, 2'b11);
        chk("same_edge:rdata_old", bus.rdata, old0);
        model_regs[0] = 32'hA5A5A5A5;
        chk("same_edge:regs", regs_o, model_flat());
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        chk("same_edge:done", {bus.bvalid, bus.rvalid}, 2'b00);
        axi_read(10'h000, 3'b001, 1, 0, "rd_reg0_new");

        // Privilege bit: honoured only in the protected build.
        axi_write(10'h00C, 32'h0BADC0DE, 4'hF, 3'b000, 0, 0, 0, "wr_unpriv");
        axi_write(10'h00C, 32'h600DC0DE, 4'hF, 3'b001, 0, 0, 0, "wr_priv");
        axi_read(10'h00C, 3'b000, 0, 0, "rd_unpriv");
        axi_read(10'h00C, 3'b001, 0, 0, "rd_priv");

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            raddr = 10'($urandom_range(0, 10) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(raddr, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rnd_wr");
            else
                axi_read(raddr, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 2), "rnd_rd");
        end

        // Async reset while a write response is pending.
        bus.awaddr = 10'h010; bus.awprot = 3'b001; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("rst_mid:bvalid_before", bus.bvalid, 1'b1);
        #2; rst_n = 1'b0; #1;
        model_reset();
        chk("rst_mid:valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("rst_mid:readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("rst_mid:regs", regs_o, model_flat());
        @(negedge clk); rst_n = 1'b1;
        bus.bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_mid:no_response", bus.bvalid, 1'b0);
        end
        bus.bready = 1'b0;
        axi_read(10'h010, 3'b001, 0, 0, "rd_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
